// File: rtl/universal_register_sequencer.sv
// Command sequencer for a 4-bit universal shift register (sel: 0 hold, 1 shr, 2 shl, 3 load).
// Optional one-entry pending command buffer when UNIREG_SEQ_PENDING_EN is defined.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a command, register held (sel=0)
// LOAD  | one cycle of parallel load (cmd_data for LOAD, zeros for CLR)
// SHIFT | N cycles of shift/rotate, counter walks N down to 1
// DONE  | one-cycle completion pulse, register held
module universal_register_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_fill,
    input  logic [WIDTH-1:0] q_parallel,
    output logic [1:0]       sel,
    output logic             d_right,
    output logic             d_left,
    output logic [WIDTH-1:0] d_parallel,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

    localparam logic [2:0] OP_LOAD = 3'd1;
    localparam logic [2:0] OP_SHR  = 3'd2;
    localparam logic [2:0] OP_SHL  = 3'd3;
    localparam logic [2:0] OP_ROR  = 3'd4;
    localparam logic [2:0] OP_ROL  = 3'd5;
    localparam logic [2:0] OP_CLR  = 3'd6;
    localparam logic [2:0] OP_RSVD = 3'd7;

    state_t             state, state_nxt, launch_state;
    logic [2:0]         op_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               fill_q;
    logic [WIDTH-1:0]   dpar_q;

    logic               accept;
    logic               launch;
    logic [2:0]         l_op;
    logic [CNT_W-1:0]   l_count;
    logic [WIDTH-1:0]   l_data;
    logic               l_fill;

    assign accept = cmd_valid && cmd_ready;

`ifdef UNIREG_SEQ_PENDING_EN
    logic               pend_full;
    logic [2:0]         pend_op;
    logic [CNT_W-1:0]   pend_count;
    logic [WIDTH-1:0]   pend_data;
    logic               pend_fill;
    logic               can_launch;

    assign cmd_ready  = !reset && !pend_full;
    assign can_launch = (state == S_IDLE) || (state == S_DONE);

    // A buffered command takes priority; cmd_ready is low while it is held.
    always_comb begin
        launch  = 1'b0;
        l_op    = cmd_op;
        l_count = cmd_count;
        l_data  = cmd_data;
        l_fill  = cmd_fill;
        if (can_launch) begin
            if (pend_full) begin
                launch  = 1'b1;
                l_op    = pend_op;
                l_count = pend_count;
                l_data  = pend_data;
                l_fill  = pend_fill;
            end else if (accept) begin
                launch = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_full  <= 1'b0;
            pend_op    <= '0;
            pend_count <= '0;
            pend_data  <= '0;
            pend_fill  <= 1'b0;
        end else if (can_launch && pend_full) begin
            pend_full <= 1'b0;
        end else if (accept && !can_launch) begin
            pend_full  <= 1'b1;
            pend_op    <= cmd_op;
            pend_count <= cmd_count;
            pend_data  <= cmd_data;
            pend_fill  <= cmd_fill;
        end
    end
`else
    assign cmd_ready = !reset && (state == S_IDLE);
    assign launch    = accept;
    assign l_op      = cmd_op;
    assign l_count   = cmd_count;
    assign l_data    = cmd_data;
    assign l_fill    = cmd_fill;
`endif

    // Zero-count shifts, NOP and the reserved op all complete immediately.
    always_comb begin
        case (l_op)
            OP_LOAD, OP_CLR:                launch_state = S_LOAD;
            OP_SHR, OP_SHL, OP_ROR, OP_ROL: launch_state = (l_count != '0) ? S_SHIFT : S_DONE;
            default:                        launch_state = S_DONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = launch ? launch_state : S_IDLE;
            S_LOAD:  state_nxt = S_DONE;
            S_SHIFT: state_nxt = (cnt_q == CNT_W'(1)) ? S_DONE : S_SHIFT;
            S_DONE:  state_nxt = launch ? launch_state : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q   <= '0;
            cnt_q  <= '0;
            fill_q <= 1'b0;
            dpar_q <= '0;
        end else if (launch) begin
            op_q   <= l_op;
            cnt_q  <= l_count;
            fill_q <= l_fill;
            if (l_op == OP_LOAD) begin
                dpar_q <= l_data;
            end else if (l_op == OP_CLR) begin
                dpar_q <= '0;
            end
        end else if (state == S_SHIFT && cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // Rotates feed the outgoing bit straight back from the register output.
    always_comb begin
        sel     = 2'd0;
        d_right = 1'b0;
        d_left  = 1'b0;
        case (state)
            S_LOAD: sel = 2'd3;
            S_SHIFT: begin
                case (op_q)
                    OP_SHR: begin sel = 2'd1; d_right = fill_q;               end
                    OP_ROR: begin sel = 2'd1; d_right = q_parallel[0];        end
                    OP_SHL: begin sel = 2'd2; d_left  = fill_q;               end
                    OP_ROL: begin sel = 2'd2; d_left  = q_parallel[WIDTH-1];  end
                    default: sel = 2'd0;
                endcase
            end
            default: sel = 2'd0;
        endcase
    end

    assign d_parallel = dpar_q;
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);
    assign err        = (state == S_DONE) && (op_q == OP_RSVD);

endmodule

// File: tb/tb_universal_register_sequencer.sv
// Directed bench for universal_register_sequencer driving a behavioural 4-bit universal register.
// Covers both builds (UNIREG_SEQ_PENDING_EN defined or not).
module tb_universal_register_sequencer;

    localparam int WIDTH = 4;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [2:0]       cmd_op = 3'd0;
    logic [CNT_W-1:0] cmd_count = '0;
    logic [WIDTH-1:0] cmd_data = '0;
    logic             cmd_fill = 1'b0;
    logic [WIDTH-1:0] q = '0;
    logic [1:0]       sel;
    logic             d_right, d_left;
    logic [WIDTH-1:0] d_parallel;
    logic             busy, done, err;

    int vectors = 0;
    int miscompares = 0;

    universal_register_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_count(cmd_count), .cmd_data(cmd_data), .cmd_fill(cmd_fill),
        .q_parallel(q),
        .sel(sel), .d_right(d_right), .d_left(d_left), .d_parallel(d_parallel),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // The register under control
    always @(posedge clk) begin
        case (sel)
            2'd1: q <= {d_right, q[WIDTH-1:1]};
            2'd2: q <= {q[WIDTH-2:0], d_left};
            2'd3: q <= d_parallel;
            default: q <= q;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present one command for one accept edge, then scramble the fields.
    task automatic issue(input logic [2:0] op, input logic [2:0] cnt,
                         input logic [3:0] data, input logic f);
        chk("ready_before_issue", {31'd0, cmd_ready}, 32'd1);
        cmd_op = op; cmd_count = cnt; cmd_data = data; cmd_fill = f;
        cmd_valid = 1'b1;
        tick;
        cmd_valid = 1'b0;
        cmd_op = 3'd7; cmd_count = 3'd5; cmd_data = ~data; cmd_fill = ~f;
    endtask

    initial begin
        // 1: reset, then LOAD 4'hC
        tick; tick;
        chk("rst_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_sel", {30'd0, sel}, 32'd0);
        chk("rst_dpar", {28'd0, d_parallel}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        reset = 1'b0;
        #1;
        chk("idle_ready", {31'd0, cmd_ready}, 32'd1);
        issue(3'd1, 3'd0, 4'hC, 1'b0);
        chk("load_sel", {30'd0, sel}, 32'd3);
        chk("load_dpar", {28'd0, d_parallel}, 32'hC);
        chk("load_ready", {31'd0, cmd_ready}, 32'd0);
        chk("load_done_early", {31'd0, done}, 32'd0);
        tick;
        chk("load_done", {31'd0, done}, 32'd1);
        chk("load_q", {28'd0, q}, 32'hC);
        chk("load_done_sel", {30'd0, sel}, 32'd0);
        tick;
        chk("load_idle_ready", {31'd0, cmd_ready}, 32'd1);
        chk("load_idle_done", {31'd0, done}, 32'd0);

        // 2: SHR count=2 fill=1 from 1100
        issue(3'd2, 3'd2, 4'h0, 1'b1);
        chk("shr_sel1", {30'd0, sel}, 32'd1);
        chk("shr_dright", {31'd0, d_right}, 32'd1);
        chk("shr_dleft", {31'd0, d_left}, 32'd0);
        tick;
        chk("shr_sel2", {30'd0, sel}, 32'd1);
        chk("shr_q1", {28'd0, q}, 32'hE);
        tick;
        chk("shr_done", {31'd0, done}, 32'd1);
        chk("shr_q2", {28'd0, q}, 32'hF);
        tick;
        tick;
        chk("shr_hold_q", {28'd0, q}, 32'hF);

        // 3: LOAD 1001, ROL 1, ROR 4
        issue(3'd1, 3'd0, 4'h9, 1'b0);
        tick; tick;
        chk("l9_q", {28'd0, q}, 32'h9);
        issue(3'd5, 3'd1, 4'h0, 1'b0);
        chk("rol_sel", {30'd0, sel}, 32'd2);
        chk("rol_dleft", {31'd0, d_left}, 32'd1);
        tick;
        chk("rol_done", {31'd0, done}, 32'd1);
        chk("rol_q", {28'd0, q}, 32'h3);
        tick;
        issue(3'd4, 3'd4, 4'h0, 1'b0);
        chk("ror_dr1", {31'd0, d_right}, 32'd1);
        chk("ror_sel", {30'd0, sel}, 32'd1);
        chk("ror_dleft", {31'd0, d_left}, 32'd0);
        tick;
        chk("ror_q1", {28'd0, q}, 32'h9);
        chk("ror_dr2", {31'd0, d_right}, 32'd1);
        tick;
        chk("ror_q2", {28'd0, q}, 32'hC);
        chk("ror_dr3", {31'd0, d_right}, 32'd0);
        tick;
        chk("ror_q3", {28'd0, q}, 32'h6);
        chk("ror_dr4", {31'd0, d_right}, 32'd0);
        chk("ror_busy4", {31'd0, done}, 32'd0);
        tick;
        chk("ror_done", {31'd0, done}, 32'd1);
        chk("ror_q4", {28'd0, q}, 32'h3);
        tick;

        // 4: SHL count=0, then reserved op
        issue(3'd3, 3'd0, 4'h0, 1'b1);
        chk("zc_done", {31'd0, done}, 32'd1);
        chk("zc_sel", {30'd0, sel}, 32'd0);
        chk("zc_err", {31'd0, err}, 32'd0);
        tick;
        issue(3'd7, 3'd3, 4'h0, 1'b0);
        chk("op7_done", {31'd0, done}, 32'd1);
        chk("op7_err", {31'd0, err}, 32'd1);
        chk("op7_sel", {30'd0, sel}, 32'd0);
        tick;
        chk("op7_err_clr", {31'd0, err}, 32'd0);
        chk("op7_q", {28'd0, q}, 32'h3);

        // 5: SHR 7 fill 0 from 1111, reset on third shift cycle
        issue(3'd1, 3'd0, 4'hF, 1'b0);
        tick; tick;
        issue(3'd2, 3'd7, 4'h0, 1'b0);
        tick; tick;
        chk("rst5_sel_pre", {30'd0, sel}, 32'd1);
        reset = 1'b1;
        tick;
        chk("rst5_sel", {30'd0, sel}, 32'd0);
        chk("rst5_busy", {31'd0, busy}, 32'd0);
        chk("rst5_done", {31'd0, done}, 32'd0);
        chk("rst5_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst5_q", {28'd0, q}, 32'h1);
        reset = 1'b0;
        tick;
        chk("rst5_no_done", {31'd0, done}, 32'd0);
        chk("rst5_q_hold", {28'd0, q}, 32'h1);

        // 6: SHL 2 offered while LOAD 5 is busy
        issue(3'd1, 3'd0, 4'h5, 1'b0);
        cmd_op = 3'd3; cmd_count = 3'd2; cmd_data = 4'h0; cmd_fill = 1'b0;
        cmd_valid = 1'b1;
`ifdef UNIREG_SEQ_PENDING_EN
        #1;
        chk("pend_ready_busy", {31'd0, cmd_ready}, 32'd1);
        tick;
        cmd_valid = 1'b0;
        chk("pend_done1", {31'd0, done}, 32'd1);
        chk("pend_ready_full", {31'd0, cmd_ready}, 32'd0);
        chk("pend_q5", {28'd0, q}, 32'h5);
        tick;
        chk("pend_sel_a", {30'd0, sel}, 32'd2);
        chk("pend_dpar", {28'd0, d_parallel}, 32'h5);
        tick;
        chk("pend_sel_b", {30'd0, sel}, 32'd2);
        chk("pend_qa", {28'd0, q}, 32'hA);
        tick;
        chk("pend_done2", {31'd0, done}, 32'd1);
        chk("pend_qb", {28'd0, q}, 32'h4);
`else
        #1;
        chk("nb_ready_busy", {31'd0, cmd_ready}, 32'd0);
        tick;
        chk("nb_done1", {31'd0, done}, 32'd1);
        chk("nb_ready_done", {31'd0, cmd_ready}, 32'd0);
        chk("nb_q5", {28'd0, q}, 32'h5);
        tick;
        chk("nb_ready_idle", {31'd0, cmd_ready}, 32'd1);
        chk("nb_idle_busy", {31'd0, busy}, 32'd0);
        tick;
        cmd_valid = 1'b0;
        chk("nb_sel_a", {30'd0, sel}, 32'd2);
        chk("nb_dpar", {28'd0, d_parallel}, 32'h5);
        tick;
        chk("nb_sel_b", {30'd0, sel}, 32'd2);
        chk("nb_qa", {28'd0, q}, 32'hA);
        tick;
        chk("nb_done2", {31'd0, done}, 32'd1);
        chk("nb_qb", {28'd0, q}, 32'h4);
`endif
        tick;
        chk("s6_idle_busy", {31'd0, busy}, 32'd0);

        // CLR drives zeros through the parallel path
        issue(3'd6, 3'd0, 4'hB, 1'b0);
        chk("clr_sel", {30'd0, sel}, 32'd3);
        chk("clr_dpar", {28'd0, d_parallel}, 32'h0);
        tick;
        chk("clr_done", {31'd0, done}, 32'd1);
        chk("clr_q", {28'd0, q}, 32'h0);
        tick;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
